// File: rtl/mem_responder.sv
// mem_responder: instruction/data memory pair for a small CPU.
// After reset the block sits in LOAD and accepts a stream of words
// into imem. Once the stream ends it switches to RUN, which releases
// the CPU. In RUN it serves one registered instruction read port and
// one registered data read/write port.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   addr_0 / inst_rdata     instruction address in, instruction word out (1-cycle latency)
//   addr_1 / data_wdata /
//   we_n / data_rdata       data address, write data, active-low write enable, read data
//   ld_valid/ld_data/
//   ld_last/ld_ready        loader stream handshake
//   run                     high once loading has completed
//   err                     sticky out-of-range access flag
//
// Build option: define MEM_FWD_EN to make a same-address read-during-write
// return the new write data. When it is undefined, the read returns the old
// memory contents.
module mem_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] addr_0,
  output logic [DATA_WIDTH-1:0] inst_rdata,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  input  logic                  we_n,
  output logic [DATA_WIDTH-1:0] data_rdata,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  run,
  output logic                  err
);

  localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
  // Range limits are one bit wider than the address so that the depth
  // itself is representable and the compare uses the full address.
  localparam logic [ADDR_WIDTH:0] ILIM     = (ADDR_WIDTH+1)'(IMEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] DLIM     = (ADDR_WIDTH+1)'(DMEM_DEPTH);
  localparam logic [IAW-1:0]      LAST_IDX = IAW'(IMEM_DEPTH - 1);

  typedef enum logic {ST_LOAD, ST_RUN} state_e;

  state_e                state_q;
  logic [IAW-1:0]        ld_cnt_q;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  run_q;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] imem [IMEM_DEPTH];
  logic [DATA_WIDTH-1:0] dmem [DMEM_DEPTH];

  logic                  ld_accept, ld_final;
  logic                  i_oor, d_oor, d_we;
  logic [IAW-1:0]        i_idx;
  logic [DAW-1:0]        d_idx;

  // ld_ready is gated by reset_n so that no word can be captured while
  // reset is held. It therefore reads 1 only once reset is released.
  assign ld_ready   = (state_q == ST_LOAD) && reset_n;
  assign inst_rdata = inst_q;
  assign data_rdata = data_q;
  assign run        = run_q;
  assign err        = err_q;

  always_comb begin
    ld_accept = ld_ready && ld_valid;
    ld_final  = ld_accept && (ld_last || (ld_cnt_q == LAST_IDX));
    i_oor     = {1'b0, addr_0} >= ILIM;
    d_oor     = {1'b0, addr_1} >= DLIM;
    i_idx     = addr_0[IAW-1:0];
    d_idx     = addr_1[DAW-1:0];
    d_we      = run_q && !we_n && !d_oor;
    inst_d    = '0;
    data_d    = '0;
    err_d     = err_q;
    if (state_q == ST_RUN) begin
      err_d = err_q | i_oor | d_oor;
      if (!i_oor) inst_d = imem[i_idx];
      if (!d_oor) begin
`ifdef MEM_FWD_EN
        data_d = d_we ? data_wdata : dmem[d_idx];
`else
        data_d = dmem[d_idx];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_LOAD;
      ld_cnt_q <= '0;
      inst_q   <= '0;
      data_q   <= '0;
      run_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      inst_q <= inst_d;
      data_q <= data_d;
      err_q  <= err_d;
      case (state_q)
        ST_LOAD: begin
          if (ld_accept) begin
            // On the final word the counter is left as is, so it never wraps.
            if (ld_final) begin
              state_q <= ST_RUN;
              run_q   <= 1'b1;
            end else begin
              ld_cnt_q <= ld_cnt_q + 1'b1;
            end
          end
        end
        ST_RUN:  ;
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  // The arrays are not reset, so their contents survive a reset.
  always_ff @(posedge clk) begin
    if (ld_accept) imem[ld_cnt_q] <= ld_data;
    if (d_we)      dmem[d_idx]    <= data_wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int ID = 256;
  localparam int DD = 256;
`ifdef MEM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] addr_0, addr_1;
  logic [DW-1:0] inst_rdata, data_wdata, data_rdata, ld_data;
  logic          we_n, ld_valid, ld_last, ld_ready, run, err;

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IMEM_DEPTH(ID), .DMEM_DEPTH(DD)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .addr_0(addr_0), .inst_rdata(inst_rdata),
    .addr_1(addr_1), .data_wdata(data_wdata), .we_n(we_n), .data_rdata(data_rdata),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .run(run), .err(err)
  );

  typedef struct {
    logic          run;
    logic          rdy;
    logic          err;
    logic [DW-1:0] inst;
    logic [DW-1:0] data;
    bit            ci;
    bit            cd;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: plain arrays plus a "known" flag per word, because
  // memory contents that were never written are undefined.
  bit            m_run;
  int            m_cnt;
  bit            m_err;
  logic [DW-1:0] m_imem [ID];
  logic [DW-1:0] m_dmem [DD];
  bit            m_ik   [ID];
  bit            m_dk   [DD];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle at the negedge, predict the outputs after the next
  // posedge, and queue the prediction for the monitor.
  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit last,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input bit wen_n, input logic [DW-1:0] wd);
    exp_t e;
    bit   ioor, door;
    int   i0, i1;
    ld_valid = v; ld_data = d; ld_last = last;
    addr_0 = a0; addr_1 = a1; we_n = wen_n; data_wdata = wd;
    e.ci = 1'b1; e.cd = 1'b1; e.inst = '0; e.data = '0;
    i0 = int'(a0); i1 = int'(a1);
    if (!m_run) begin
      if (v) begin
        m_imem[m_cnt] = d;
        m_ik[m_cnt]   = 1'b1;
        if (last || m_cnt == ID - 1) m_run = 1'b1;
        else m_cnt++;
      end
    end else begin
      ioor = i0 >= ID;
      door = i1 >= DD;
      if (ioor || door) m_err = 1'b1;
      if (!ioor) begin
        e.ci = m_ik[i0];
        e.inst = m_imem[i0];
      end
      if (!door) begin
        if (!wen_n && FWD) e.data = wd;
        else begin
          e.cd = m_dk[i1];
          e.data = m_dmem[i1];
        end
        if (!wen_n) begin
          m_dmem[i1] = wd;
          m_dk[i1] = 1'b1;
        end
      end
    end
    e.run = m_run;
    e.rdy = !m_run;
    e.err = m_err;
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    cycle(1'b0, '0, 1'b0, a0, a1, 1'b1, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a1, input logic [DW-1:0] wd);
    cycle(1'b0, '0, 1'b0, '0, a1, 1'b0, wd);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; ld_valid = 1'b0; we_n = 1'b1;
    #2;
    chk("rst_run", 32'(run), 0);
    chk("rst_ld_ready", 32'(ld_ready), 0);
    chk("rst_inst", 32'(inst_rdata), 0);
    chk("rst_data", 32'(data_rdata), 0);
    chk("rst_err", 32'(err), 0);
    m_run = 1'b0; m_cnt = 0; m_err = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rel_ld_ready", 32'(ld_ready), 1);
    @(negedge clk);
  endtask

  // Monitor: outputs are valid every cycle, so one prediction is popped
  // per posedge whenever one is pending.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        chk("run", 32'(run), 32'(e.run));
        chk("ld_ready", 32'(ld_ready), 32'(e.rdy));
        chk("err", 32'(err), 32'(e.err));
        if (e.ci) chk("inst_rdata", 32'(inst_rdata), 32'(e.inst));
        if (e.cd) chk("data_rdata", 32'(data_rdata), 32'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] a0, a1;
    int guard;
    reset_n = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    addr_0 = '0; addr_1 = '0; we_n = 1'b1; data_wdata = '0;
    for (int i = 0; i < ID; i++) m_ik[i] = 1'b0;
    for (int i = 0; i < DD; i++) m_dk[i] = 1'b0;
    @(negedge clk);
    do_reset();

    // Four-word load with an idle gap; we_n is active but must be ignored.
    cycle(1'b1, 16'h7800, 1'b0, 16'h0000, 16'h0020, 1'b0, 16'hAAAA);
    cycle(1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0020, 1'b0, 16'hAAAA);
    cycle(1'b1, 16'h7400, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000);
    cycle(1'b1, 16'h7020, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000);
    cycle(1'b1, 16'h7001, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'h0000);

    // Instruction reads with one-cycle latency.
    rd(16'h0002, 16'h0000);
    rd(16'h0000, 16'h0000);
    rd(16'h0003, 16'h0000);
    rd(16'h0001, 16'h0000);

    // Write, read back, then read-during-write to the same address.
    wr(16'h0010, 16'hBEEF);
    rd(16'h0000, 16'h0010);
    wr(16'h0010, 16'h1234);
    rd(16'h0000, 16'h0010);

    // Range boundaries: last valid word, first invalid word, and the maximum address.
    wr(16'h00FF, 16'hC0DE);
    rd(16'h0002, 16'h00FF);
    wr(16'h0000, 16'h5555);
    wr(16'h0100, 16'hDEAD);
    rd(16'h0000, 16'h0000);
    rd(16'h0100, 16'h0010);
    wr(16'hFFFF, 16'h0BAD);
    rd(16'h0001, 16'h00FF);

    // Random traffic in RUN; ld_valid toggles but must be ignored.
    for (int k = 0; k < 200; k++) begin
      a0 = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 15) == 0) a0 = 16'($urandom);
      a1 = 16'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) a1 = 16'($urandom);
      cycle(1'($urandom), 16'($urandom), 1'($urandom), a0, a1, 1'($urandom), 16'($urandom));
    end

    // Reset while loading: two words, reset, then a one-word reload.
    wr(16'h0010, 16'h1234);
    do_reset();
    cycle(1'b1, 16'h1111, 1'b0, 16'h0000, 16'h0010, 1'b0, 16'hDEAD);
    cycle(1'b1, 16'h2222, 1'b0, 16'h0000, 16'h0010, 1'b0, 16'hDEAD);
    do_reset();
    cycle(1'b1, 16'h3333, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'h0000);
    rd(16'h0000, 16'h0010);
    rd(16'h0001, 16'h0000);
    rd(16'h0002, 16'h0000);
    rd(16'h0000, 16'h0010);

    // Full-depth load without ld_last must stop at the last word.
    do_reset();
    guard = 0;
    while (!m_run && guard < 2000) begin
      guard++;
      cycle(($urandom_range(0, 3) != 0), 16'($urandom), 1'b0, '0, '0, 1'b1, '0);
    end
    cycle(1'b1, 16'hFFFF, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'h0000);
    rd(16'h00FF, 16'h0000);
    rd(16'h0000, 16'h0000);
    for (int k = 0; k < 100; k++) begin
      rd(16'($urandom_range(0, ID - 1)), 16'($urandom_range(0, 31)));
    end

    rd(16'h0000, 16'h0000);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
